// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg
// Shared definitions for the control-bundle pipeline: default bundle width,
// the bit positions of each decoded control field inside the bundle, a packed
// view of the bundle, and the per-slice update operation used by
// ctrl_pipe_stage.
// No ports (package).
package ctrl_pipe_pkg;

  localparam int CTRL_W_DEF = 16;

  // Single-bit field positions.
  localparam int MEM_READ_BIT      = 0;
  localparam int MEM_WRITE_BIT     = 1;
  localparam int ALU_SRC_BIT       = 2;
  localparam int REG_WRITE_BIT     = 3;
  localparam int MEM_TO_REG_BIT    = 4;
  localparam int CSR_REG_WRITE_BIT = 5;
  localparam int CSR_INST_BIT      = 6;

  // Multi-bit field ranges.
  localparam int ALU_OP_LSB   = 7;
  localparam int ALU_OP_MSB   = 8;
  localparam int CSR_CTRL_LSB = 9;
  localparam int CSR_CTRL_MSB = 12;
  localparam int RSVD_LSB     = 13;
  localparam int RSVD_MSB     = 15;

  // Packed view of the default 16-bit bundle, MSB first.
  typedef struct packed {
    logic [2:0] reserved;
    logic [3:0] csr_ctrl;
    logic [1:0] alu_op;
    logic       csr_inst;
    logic       csr_reg_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
  } ctrl_bundle_t;

  // What a slice does on the next edge.
  //   SLICE_LOAD      : take the upstream bundle and its valid bit
  //   SLICE_HOLD      : keep current contents (frozen)
  //   SLICE_BUBBLE_IN : take the upstream bundle as a bubble (valid 0)
  //   SLICE_KILL      : turn the current contents into a bubble
  typedef enum logic [1:0] {
    SLICE_LOAD      = 2'd0,
    SLICE_HOLD      = 2'd1,
    SLICE_BUBBLE_IN = 2'd2,
    SLICE_KILL      = 2'd3
  } slice_op_e;

  // True when the bundle touches data memory.
  function automatic logic is_mem_op(input ctrl_bundle_t b);
    return b.mem_read | b.mem_write;
  endfunction

  // True when the bundle writes any architectural register.
  function automatic logic writes_reg(input ctrl_bundle_t b);
    return b.reg_write | b.csr_reg_write;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage
// One register slice of the control-bundle pipeline: bundle register, valid
// bit, and the flush / hold / bubble-injection mux in front of them.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           kill this slice (current contents become a bubble)
//   hold            effective freeze of this slice (already rippled)
//   inject          load the upstream bundle as a bubble instead of as-is
//   ctrl_in         upstream bundle
//   valid_in        upstream valid bit
//   ctrl_out        registered bundle
//   valid_out       registered valid bit
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int                CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] BUBBLE_MASK = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              inject,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [CTRL_W-1:0] ctrl_d;
  logic              valid_q;
  logic              valid_d;
  slice_op_e         op;

  // Flush beats hold: a killed slice must not survive a freeze.
  always_comb begin
    op      = SLICE_LOAD;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;

    if (flush) begin
      op = SLICE_KILL;
    end else if (hold) begin
      op = SLICE_HOLD;
    end else if (inject) begin
      op = SLICE_BUBBLE_IN;
    end

    unique case (op)
      SLICE_KILL: begin
        ctrl_d  = ctrl_q & ~BUBBLE_MASK;
        valid_d = 1'b0;
      end
      SLICE_HOLD: begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
      end
      SLICE_BUBBLE_IN: begin
        ctrl_d  = ctrl_in & ~BUBBLE_MASK;
        valid_d = 1'b0;
      end
      SLICE_LOAD: begin
        ctrl_d  = ctrl_in;
        valid_d = valid_in;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign ctrl_out  = ctrl_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/ctrl_bubble_pipe.sv
// ctrl_bubble_pipe
// Carries decoded ID-stage control bundles through STAGES register slices,
// inserting bubbles on ID stall/NOP and honouring per-slice hold and flush.
// Also keeps saturating retire and bubble counters.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   ctrl_in      decoded control bundle from ID
//   stall, nop   ID hazard stall / NOP-or-branch-kill; bubble into slice 0
//   hold         per-slice freeze request
//   flush        per-slice kill
//   ctrl_out     slice i bundle at [i*CTRL_W +: CTRL_W]
//   valid_out    slice i holds a real instruction
//   retire       last slice valid and leaving this cycle (combinational)
//   retire_cnt   saturating count of retired instructions
//   bubble_cnt   saturating count of bubbles injected at ID
module ctrl_bubble_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int                CTRL_W      = CTRL_W_DEF,
  parameter int                STAGES      = 3,
  parameter logic [CTRL_W-1:0] BUBBLE_MASK = {CTRL_W{1'b1}},
  parameter int                CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic                     stall,
  input  logic                     nop,
  input  logic [STAGES-1:0]        hold,
  input  logic [STAGES-1:0]        flush,
  output logic [STAGES*CTRL_W-1:0] ctrl_out,
  output logic [STAGES-1:0]        valid_out,
  output logic                     retire,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  logic [STAGES-1:0] eh;
  logic              eh_acc;
  logic [CTRL_W-1:0] slice_ctrl  [STAGES];
  logic              slice_valid [STAGES];
  logic              id_bubble;
  logic              bubble_evt;

  logic [CNT_W-1:0]  retire_cnt_q;
  logic [CNT_W-1:0]  retire_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_d;

  // A frozen slice freezes everything upstream of it, so the effective hold
  // ripples from the last slice back towards ID. A scalar accumulator keeps
  // this from looking like a combinational loop on eh itself.
  always_comb begin
    eh     = '0;
    eh_acc = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      eh_acc = eh_acc | hold[i];
      eh[i]  = eh_acc;
    end
  end

  assign id_bubble = stall | nop;

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    logic [CTRL_W-1:0] up_ctrl;
    logic              up_valid;
    logic              up_inject;

    if (g == 0) begin : g_head
      assign up_ctrl   = ctrl_in;
      assign up_valid  = 1'b1;
      assign up_inject = id_bubble;
    end else begin : g_body
      // A frozen predecessor is not advancing, so what this slice sees
      // must not count as a real instruction.
      assign up_ctrl   = slice_ctrl[g-1];
      assign up_valid  = slice_valid[g-1];
      assign up_inject = eh[g-1];
    end

    ctrl_pipe_stage #(
      .CTRL_W      (CTRL_W),
      .BUBBLE_MASK (BUBBLE_MASK)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[g]),
      .hold      (eh[g]),
      .inject    (up_inject),
      .ctrl_in   (up_ctrl),
      .valid_in  (up_valid),
      .ctrl_out  (slice_ctrl[g]),
      .valid_out (slice_valid[g])
    );

    assign ctrl_out[g*CTRL_W +: CTRL_W] = slice_ctrl[g];
    assign valid_out[g]                 = slice_valid[g];
  end

  assign retire     = slice_valid[STAGES-1] & ~hold[STAGES-1] & ~flush[STAGES-1];
  assign bubble_evt = ~eh[0] & ~flush[0] & id_bubble;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (retire && (retire_cnt_q != {CNT_W{1'b1}})) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
    if (bubble_evt && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_ctrl_bubble_pipe.sv
// tb_ctrl_bubble_pipe
// Two pipes share one stimulus stream: pipe A uses the default full bubble
// mask and 32-bit counters, pipe B uses mask 16'hFFF0 and 4-bit counters.
// A behavioural model of both pipes is advanced alongside every clock edge.
module tb_ctrl_bubble_pipe;

  localparam int          W      = 16;
  localparam int          S      = 3;
  localparam logic [15:0] MASK_A = 16'hFFFF;
  localparam logic [15:0] MASK_B = 16'hFFF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst     = 1'b0;
  logic [W-1:0] ctrl_in = '0;
  logic         stall   = 1'b0;
  logic         nop     = 1'b0;
  logic [S-1:0] hold    = '0;
  logic [S-1:0] flush   = '0;

  logic [S*W-1:0] a_ctrl_out, b_ctrl_out;
  logic [S-1:0]   a_valid_out, b_valid_out;
  logic           a_retire, b_retire;
  logic [31:0]    a_retire_cnt, a_bubble_cnt;
  logic [3:0]     b_retire_cnt, b_bubble_cnt;

  int checks = 0;
  int errors = 0;

  ctrl_bubble_pipe #(
    .CTRL_W(W), .STAGES(S), .BUBBLE_MASK(MASK_A), .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .stall(stall), .nop(nop),
    .hold(hold), .flush(flush), .ctrl_out(a_ctrl_out), .valid_out(a_valid_out),
    .retire(a_retire), .retire_cnt(a_retire_cnt), .bubble_cnt(a_bubble_cnt)
  );

  ctrl_bubble_pipe #(
    .CTRL_W(W), .STAGES(S), .BUBBLE_MASK(MASK_B), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .stall(stall), .nop(nop),
    .hold(hold), .flush(flush), .ctrl_out(b_ctrl_out), .valid_out(b_valid_out),
    .retire(b_retire), .retire_cnt(b_retire_cnt), .bubble_cnt(b_bubble_cnt)
  );

  // Behavioural model: index 0 = pipe A, index 1 = pipe B.
  logic [W-1:0] m_ctrl  [2][S];
  logic         m_valid [2][S];
  longint       m_ret   [2];
  longint       m_bub   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ret[k] = 0;
      m_bub[k] = 0;
      for (int i = 0; i < S; i++) begin
        m_ctrl[k][i]  = '0;
        m_valid[k][i] = 1'b0;
      end
    end
  end

  // A slice is frozen if it or any slice downstream of it asks to hold.
  function automatic bit frozen(input int i);
    for (int j = i; j < S; j++) if (hold[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_retire(input int k);
    return m_valid[k][S-1] && !hold[S-1] && !flush[S-1];
  endfunction

  // Advance the model from the present inputs, then take one clock edge.
  task automatic tick();
    logic [W-1:0] n_ctrl  [2][S];
    logic         n_valid [2][S];
    longint       n_ret   [2];
    longint       n_bub   [2];
    logic [W-1:0] mask;
    longint       cmax;
    for (int k = 0; k < 2; k++) begin
      mask     = (k == 0) ? MASK_A : MASK_B;
      cmax     = (k == 0) ? 64'd4294967295 : 64'd15;
      n_ret[k] = m_ret[k];
      n_bub[k] = m_bub[k];
      if (model_retire(k) && m_ret[k] < cmax) n_ret[k] = m_ret[k] + 1;
      if (!frozen(0) && !flush[0] && (stall || nop) && m_bub[k] < cmax)
        n_bub[k] = m_bub[k] + 1;
      for (int i = 0; i < S; i++) begin
        if (flush[i]) begin
          n_ctrl[k][i] = m_ctrl[k][i] & ~mask; n_valid[k][i] = 1'b0;
        end else if (frozen(i)) begin
          n_ctrl[k][i] = m_ctrl[k][i]; n_valid[k][i] = m_valid[k][i];
        end else if (i == 0) begin
          if (stall || nop) begin
            n_ctrl[k][i] = ctrl_in & ~mask; n_valid[k][i] = 1'b0;
          end else begin
            n_ctrl[k][i] = ctrl_in; n_valid[k][i] = 1'b1;
          end
        end else if (frozen(i-1)) begin
          n_ctrl[k][i] = m_ctrl[k][i-1] & ~mask; n_valid[k][i] = 1'b0;
        end else begin
          n_ctrl[k][i] = m_ctrl[k][i-1]; n_valid[k][i] = m_valid[k][i-1];
        end
        if (rst) begin
          n_ctrl[k][i] = '0; n_valid[k][i] = 1'b0;
        end
      end
      if (rst) begin
        n_ret[k] = 0; n_bub[k] = 0;
      end
    end
    @(posedge clk);
    m_ctrl  = n_ctrl;
    m_valid = n_valid;
    m_ret   = n_ret;
    m_bub   = n_bub;
    #1;
  endtask

  task automatic fill_cba();
    ctrl_in = 16'hCCCC; tick();
    ctrl_in = 16'hBBBB; tick();
    ctrl_in = 16'hAAAA; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (a_ctrl_out !== '0) begin errors++; $display("[TB] FAIL reset_a_ctrl: got %h want 0", a_ctrl_out); end
    checks++; if (a_valid_out !== '0) begin errors++; $display("[TB] FAIL reset_a_valid: got %b want 000", a_valid_out); end
    checks++; if (a_retire_cnt !== 32'd0 || a_bubble_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_a_cnt: got %0d/%0d want 0/0", a_retire_cnt, a_bubble_cnt); end
    checks++; if (b_ctrl_out !== '0 || b_valid_out !== '0) begin errors++; $display("[TB] FAIL reset_b: got %h/%b want 0/000", b_ctrl_out, b_valid_out); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    ctrl_in = 16'h0A5C;
    tick();
    checks++; if (a_ctrl_out[15:0] !== 16'h0A5C || a_valid_out[0] !== 1'b1) begin errors++; $display("[TB] FAIL stream_s0: got %h/%b want 0a5c/1", a_ctrl_out[15:0], a_valid_out[0]); end
    tick();
    tick();
    checks++; if (a_ctrl_out[47:32] !== 16'h0A5C || a_valid_out[2] !== 1'b1) begin errors++; $display("[TB] FAIL stream_s2: got %h/%b want 0a5c/1", a_ctrl_out[47:32], a_valid_out[2]); end
    checks++; if (a_retire !== 1'b1) begin errors++; $display("[TB] FAIL stream_retire: got %b want 1", a_retire); end
    tick();
    checks++; if (a_retire_cnt !== 32'd1) begin errors++; $display("[TB] FAIL stream_retire_cnt: got %0d want 1", a_retire_cnt); end
  endtask

  task automatic test_stall();
    ctrl_in = 16'h1111;
    tick();
    stall = 1'b1; ctrl_in = 16'h00FF;
    tick();
    stall = 1'b0;
    checks++; if (a_ctrl_out[15:0] !== 16'h0000 || a_valid_out[0] !== 1'b0) begin errors++; $display("[TB] FAIL stall_s0: got %h/%b want 0000/0", a_ctrl_out[15:0], a_valid_out[0]); end
    checks++; if (a_ctrl_out[31:16] !== 16'h1111 || a_valid_out[1] !== 1'b1) begin errors++; $display("[TB] FAIL stall_s1: got %h/%b want 1111/1", a_ctrl_out[31:16], a_valid_out[1]); end
    checks++; if (a_bubble_cnt !== 32'd1) begin errors++; $display("[TB] FAIL stall_bubble_cnt: got %0d want 1", a_bubble_cnt); end
    checks++; if (b_ctrl_out[15:0] !== 16'h000F || b_bubble_cnt !== 4'd1) begin errors++; $display("[TB] FAIL stall_b_mask: got %h/%0d want 000f/1", b_ctrl_out[15:0], b_bubble_cnt); end
  endtask

  task automatic test_backpressure();
    fill_cba();
    hold = 3'b100; stall = 1'b1; ctrl_in = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (a_retire !== 1'b0) begin errors++; $display("[TB] FAIL bp_retire[%0d]: got %b want 0", c, a_retire); end
      tick();
      checks++; if (a_ctrl_out !== {16'hCCCC, 16'hBBBB, 16'hAAAA} || a_valid_out !== 3'b111) begin errors++; $display("[TB] FAIL bp_frozen[%0d]: got %h/%b want ccccbbbbaaaa/111", c, a_ctrl_out, a_valid_out); end
      checks++; if (a_bubble_cnt !== 32'd1) begin errors++; $display("[TB] FAIL bp_bubble_cnt[%0d]: got %0d want 1", c, a_bubble_cnt); end
    end
    hold = '0; stall = 1'b0;
  endtask

  task automatic test_middle_hold();
    fill_cba();
    hold = 3'b010; ctrl_in = 16'hDDDD;
    #1;
    checks++; if (a_retire !== 1'b1) begin errors++; $display("[TB] FAIL mid_retire: got %b want 1", a_retire); end
    tick();
    hold = '0;
    checks++; if (a_ctrl_out !== {16'h0000, 16'hBBBB, 16'hAAAA} || a_valid_out !== 3'b011) begin errors++; $display("[TB] FAIL mid_hold_a: got %h/%b want 0000bbbbaaaa/011", a_ctrl_out, a_valid_out); end
    checks++; if (b_ctrl_out !== {16'h000B, 16'hBBBB, 16'hAAAA}) begin errors++; $display("[TB] FAIL mid_hold_b: got %h want 000bbbbbaaaa", b_ctrl_out); end
  endtask

  task automatic test_flush_vs_hold();
    fill_cba();
    flush = 3'b010; hold = 3'b010;
    tick();
    flush = '0; hold = '0;
    checks++; if (a_ctrl_out !== {16'h0000, 16'h0000, 16'hAAAA} || a_valid_out !== 3'b001) begin errors++; $display("[TB] FAIL fvh_a: got %h/%b want 00000000aaaa/001", a_ctrl_out, a_valid_out); end
    checks++; if (b_ctrl_out !== {16'h000B, 16'h000B, 16'hAAAA} || b_valid_out !== 3'b001) begin errors++; $display("[TB] FAIL fvh_b: got %h/%b want 000b000baaaa/001", b_ctrl_out, b_valid_out); end
    ctrl_in = 16'h1237;
    tick();
    flush = 3'b001;
    tick();
    flush = '0;
    checks++; if (b_ctrl_out[15:0] !== 16'h0007 || b_valid_out[0] !== 1'b0) begin errors++; $display("[TB] FAIL flush_mask_b: got %h/%b want 0007/0", b_ctrl_out[15:0], b_valid_out[0]); end
    checks++; if (a_ctrl_out[15:0] !== 16'h0000) begin errors++; $display("[TB] FAIL flush_mask_a: got %h want 0000", a_ctrl_out[15:0]); end
  endtask

  task automatic test_saturation();
    ctrl_in = 16'h5555;
    for (int c = 0; c < 20; c++) tick();
    #1;
    checks++; if (b_retire_cnt !== 4'hF) begin errors++; $display("[TB] FAIL sat_b_retire_cnt: got %h want f", b_retire_cnt); end
    checks++; if (b_retire !== 1'b1) begin errors++; $display("[TB] FAIL sat_b_retire: got %b want 1", b_retire); end
    checks++; if (a_retire_cnt !== 32'(m_ret[0])) begin errors++; $display("[TB] FAIL sat_a_retire_cnt: got %0d want %0d", a_retire_cnt, m_ret[0]); end
  endtask

  task automatic test_midop_reset();
    rst = 1'b1;
    tick();
    checks++; if (a_ctrl_out !== '0 || a_valid_out !== '0 || a_retire !== 1'b0) begin errors++; $display("[TB] FAIL midrst_a: got %h/%b/%b want 0/000/0", a_ctrl_out, a_valid_out, a_retire); end
    checks++; if (a_retire_cnt !== 32'd0 || a_bubble_cnt !== 32'd0) begin errors++; $display("[TB] FAIL midrst_a_cnt: got %0d/%0d want 0/0", a_retire_cnt, a_bubble_cnt); end
    checks++; if (b_ctrl_out !== '0 || b_valid_out !== '0 || b_retire_cnt !== 4'd0 || b_bubble_cnt !== 4'd0) begin errors++; $display("[TB] FAIL midrst_b: got %h/%b/%0d/%0d want 0", b_ctrl_out, b_valid_out, b_retire_cnt, b_bubble_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(63) == 0);
      ctrl_in = W'($urandom);
      stall   = ($urandom_range(4) == 0);
      nop     = ($urandom_range(5) == 0);
      for (int i = 0; i < S; i++) begin
        hold[i]  = ($urandom_range(5) == 0);
        flush[i] = ($urandom_range(7) == 0);
      end
      #1;
      checks++; if (a_retire !== model_retire(0) || b_retire !== model_retire(1)) begin errors++; $display("[TB] FAIL rnd_retire[%0d]: got %b/%b want %b/%b", c, a_retire, b_retire, model_retire(0), model_retire(1)); end
      tick();
      for (int i = 0; i < S; i++) begin
        checks++; if (a_ctrl_out[i*W +: W] !== m_ctrl[0][i] || a_valid_out[i] !== m_valid[0][i]) begin errors++; $display("[TB] FAIL rnd_a_slice%0d[%0d]: got %h/%b want %h/%b", i, c, a_ctrl_out[i*W +: W], a_valid_out[i], m_ctrl[0][i], m_valid[0][i]); end
        checks++; if (b_ctrl_out[i*W +: W] !== m_ctrl[1][i] || b_valid_out[i] !== m_valid[1][i]) begin errors++; $display("[TB] FAIL rnd_b_slice%0d[%0d]: got %h/%b want %h/%b", i, c, b_ctrl_out[i*W +: W], b_valid_out[i], m_ctrl[1][i], m_valid[1][i]); end
      end
      checks++; if (a_retire_cnt !== 32'(m_ret[0]) || a_bubble_cnt !== 32'(m_bub[0])) begin errors++; $display("[TB] FAIL rnd_a_cnt[%0d]: got %0d/%0d want %0d/%0d", c, a_retire_cnt, a_bubble_cnt, m_ret[0], m_bub[0]); end
      checks++; if (b_retire_cnt !== 4'(m_ret[1]) || b_bubble_cnt !== 4'(m_bub[1])) begin errors++; $display("[TB] FAIL rnd_b_cnt[%0d]: got %0d/%0d want %0d/%0d", c, b_retire_cnt, b_bubble_cnt, m_ret[1], m_bub[1]); end
    end
    rst = 1'b0; stall = 1'b0; nop = 1'b0; hold = '0; flush = '0;
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_backpressure();
    test_middle_hold();
    test_flush_vs_hold();
    test_saturation();
    test_midop_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
